// File: rtl/ram_write_sequencer_if.sv
// Fill control and RAM write port between the write sequencer and its environment.
// master is the sequencer's view; slave is the RAM/top-level view.
interface ram_write_sequencer_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 4
);
   logic              fill_start;
   logic [1:0]        fill_mode;
   logic [DATA_W-1:0] fill_seed;
   logic              busy;
   logic              fill_done;
   logic [ADDR_W-1:0] wraddress;
   logic [DATA_W-1:0] data;
   logic              wren;

   modport master (
      input  fill_start, fill_mode, fill_seed,
      output busy, fill_done, wraddress, data, wren
   );

   modport slave (
      output fill_start, fill_mode, fill_seed,
      input  busy, fill_done, wraddress, data, wren
   );
endinterface

// File: rtl/ram_write_sequencer.sv
// Write-side controller for the dual-port RAM: one manual write per synchronized key press,
// or a bulk fill of every word with a selectable pattern.
module ram_write_sequencer #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 4,
   parameter int unsigned CNT_W  = 6
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 wr_key_n,
   input  logic [ADDR_W-1:0]    man_addr,
   input  logic [DATA_W-1:0]    man_data,
   output logic [CNT_W-1:0]     man_count,
   ram_write_sequencer_if.master bus
);

   typedef enum logic [0:0] {StIdle, StFill} state_e;

   localparam logic [CNT_W-1:0] CntMax = '1;

   state_e            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] seed_q, seed_d;
   logic [ADDR_W-1:0] wraddress_q, wraddress_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              wren_q, wren_d;
   logic              fill_done_q, fill_done_d;
   logic [CNT_W-1:0]  man_count_q, man_count_d;
   logic              s1_q, s2_q, prev_q;
   logic              press;
   logic [DATA_W-1:0] addr_lo;
   logic [DATA_W-1:0] fill_word;

   // Edge tracking runs in every state so a key held across a fill never fires afterwards.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         s1_q   <= wr_key_n;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign press = !s2_q && prev_q;

   assign addr_lo = DATA_W'(cnt_q[ADDR_W-1:0]);

   always_comb begin
      fill_word = '0;
      unique case (mode_q)
         2'b00:   fill_word = seed_q;
         2'b01:   fill_word = seed_q + addr_lo;
         2'b10:   fill_word = addr_lo ^ seed_q;
         default: fill_word = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      seed_d      = seed_q;
      wraddress_d = wraddress_q;
      data_d      = data_q;
      wren_d      = 1'b0;
      fill_done_d = 1'b0;
      man_count_d = man_count_q;
      unique case (state_q)
         StIdle: begin
            if (bus.fill_start) begin
               mode_d  = bus.fill_mode;
               seed_d  = bus.fill_seed;
               cnt_d   = '0;
               state_d = StFill;
            end else if (press) begin
               wren_d      = 1'b1;
               wraddress_d = man_addr;
               data_d      = man_data;
               if (man_count_q != CntMax) man_count_d = man_count_q + 1'b1;
            end
         end
         StFill: begin
            // Counter MSB set means every word has been written.
            if (cnt_q[ADDR_W]) begin
               fill_done_d = 1'b1;
               state_d     = StIdle;
            end else begin
               wren_d      = 1'b1;
               wraddress_d = cnt_q[ADDR_W-1:0];
               data_d      = fill_word;
               cnt_d       = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         mode_q      <= '0;
         seed_q      <= '0;
         wraddress_q <= '0;
         data_q      <= '0;
         wren_q      <= 1'b0;
         fill_done_q <= 1'b0;
         man_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         seed_q      <= seed_d;
         wraddress_q <= wraddress_d;
         data_q      <= data_d;
         wren_q      <= wren_d;
         fill_done_q <= fill_done_d;
         man_count_q <= man_count_d;
      end
   end

   assign bus.wraddress = wraddress_q;
   assign bus.data      = data_q;
   assign bus.wren      = wren_q;
   assign bus.fill_done = fill_done_q;
   assign bus.busy      = (state_q == StFill);
   assign man_count     = man_count_q;

endmodule

// File: tb/tb_ram_write_sequencer.sv
// Directed self-checking bench for ram_write_sequencer: manual presses, fills, conflicts,
// asynchronous reset mid-fill and counter saturation.
module tb_ram_write_sequencer;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned CNT_W  = 6;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              wr_key_n;
   logic [ADDR_W-1:0] man_addr;
   logic [DATA_W-1:0] man_data;
   logic [CNT_W-1:0]  man_count;
   int                compared   = 0;
   int                mismatched = 0;
   int                exp_cnt    = 0;

   ram_write_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ram_write_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .wr_key_n  (wr_key_n),
      .man_addr  (man_addr),
      .man_data  (man_data),
      .man_count (man_count),
      .bus       (bus.master)
   );

   initial forever #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_wren"}, bus.wren, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.fill_done, 0);
   endtask

   // Key goes low just after an edge; the write is expected at the 3rd edge after that.
   task automatic press(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      man_addr = a;
      man_data = d;
      wr_key_n = 1'b0;
      step(); check("press_lat1_wren", bus.wren, 0);
      step(); check("press_lat2_wren", bus.wren, 0);
      step();
      exp_cnt = (exp_cnt == 63) ? 63 : exp_cnt + 1;
      check("press_wren", bus.wren, 1);
      check("press_addr", bus.wraddress, a);
      check("press_data", bus.data, d);
      check("press_count", man_count, exp_cnt);
      step(); check("press_single_wren", bus.wren, 0);
      wr_key_n = 1'b1;
      repeat (3) begin
         step(); check("press_release_wren", bus.wren, 0);
      end
   endtask

   function automatic logic [DATA_W-1:0] pattern(input logic [1:0] mode,
                                                 input logic [DATA_W-1:0] seed,
                                                 input int addr);
      logic [DATA_W-1:0] a;
      a = addr[DATA_W-1:0];
      case (mode)
         2'b00:   return seed;
         2'b01:   return seed + a;
         2'b10:   return a ^ seed;
         default: return '0;
      endcase
   endfunction

   // With inject set, a key press and a second fill_start land in the middle of the fill.
   task automatic fill(input logic [1:0] mode, input logic [DATA_W-1:0] seed, input bit inject);
      bus.fill_start = 1'b1;
      bus.fill_mode  = mode;
      bus.fill_seed  = seed;
      step();
      bus.fill_start = 1'b0;
      bus.fill_mode  = ~mode;
      bus.fill_seed  = ~seed;
      check("fill_enter_busy", bus.busy, 1);
      check("fill_enter_wren", bus.wren, 0);
      for (int i = 0; i < 32; i++) begin
         if (inject && i == 5) wr_key_n = 1'b0;
         if (inject && i == 10) bus.fill_start = 1'b1;
         if (inject && i == 11) bus.fill_start = 1'b0;
         step();
         check("fill_wren", bus.wren, 1);
         check("fill_addr", bus.wraddress, i);
         check("fill_data", bus.data, pattern(mode, seed, i));
         check("fill_busy", bus.busy, 1);
         check("fill_done_early", bus.fill_done, 0);
      end
      step();
      check("fill_end_wren", bus.wren, 0);
      check("fill_end_busy", bus.busy, 0);
      check("fill_end_done", bus.fill_done, 1);
      check("fill_end_addr", bus.wraddress, 31);
      step();
      check("fill_done_single", bus.fill_done, 0);
      check("fill_after_busy", bus.busy, 0);
   endtask

   initial begin
      reset_n        = 1'b0;
      wr_key_n       = 1'b1;
      man_addr       = '0;
      man_data       = '0;
      bus.fill_start = 1'b0;
      bus.fill_mode  = 2'b00;
      bus.fill_seed  = '0;
      #2;
      check_quiet("reset");
      check("reset_addr", bus.wraddress, 0);
      check("reset_data", bus.data, 0);
      check("reset_count", man_count, 0);
      step();
      step();
      reset_n = 1'b1;

      repeat (10) begin
         step();
         check_quiet("idle");
         check("idle_addr", bus.wraddress, 0);
         check("idle_data", bus.data, 0);
         check("idle_count", man_count, 0);
      end

      press(5'h06, 4'hA);
      press(5'h16, 4'h6);

      fill(2'b01, 4'h3, 1'b0);

      // Press and second fill_start inside a mode-00 fill; key held past the end.
      fill(2'b00, 4'h7, 1'b1);
      repeat (5) begin
         step();
         check("held_key_wren", bus.wren, 0);
         check("held_key_count", man_count, exp_cnt);
      end
      wr_key_n = 1'b1;
      repeat (3) step();

      // Press and fill_start in the same idle cycle: fill wins.
      wr_key_n = 1'b0;
      step();
      step();
      fill(2'b10, 4'hC, 1'b0);
      repeat (4) begin
         step();
         check("collide_wren", bus.wren, 0);
         check("collide_count", man_count, exp_cnt);
      end
      wr_key_n = 1'b1;
      repeat (3) step();

      // Asynchronous reset at fill address 12.
      bus.fill_start = 1'b1;
      bus.fill_mode  = 2'b10;
      bus.fill_seed  = 4'h5;
      step();
      bus.fill_start = 1'b0;
      for (int i = 0; i <= 12; i++) begin
         step();
         check("rfill_addr", bus.wraddress, i);
      end
      #2 reset_n = 1'b0;
      #1;
      check_quiet("async_reset");
      check("async_reset_addr", bus.wraddress, 0);
      check("async_reset_data", bus.data, 0);
      check("async_reset_count", man_count, 0);
      exp_cnt = 0;
      step();
      reset_n = 1'b1;
      repeat (40) begin
         step();
         check("post_reset_wren", bus.wren, 0);
         check("post_reset_busy", bus.busy, 0);
      end
      fill(2'b11, 4'h9, 1'b0);

      for (int n = 0; n < 70; n++) begin
         man_addr = ADDR_W'(n);
         press(ADDR_W'(n + 3), DATA_W'(n));
      end
      check("saturated_count", man_count, 63);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
